bcd_counter_mux7seg: RTL
========================

# bcd_counter_mux7seg

Parametrised multi-digit BCD up/down counter with synchronous load, wrap carry, and a time-multiplexed seven-segment driver. It generalises the single-digit BCD-to-7-segment counter to DIGITS decades sharing one segment bus, with per-digit anode select, selectable output polarity and optional leading-zero blanking. It sits between board-level control inputs (buttons and switches, already synchronised) and the display pins.

## Interface
- DIGITS, 4: number of BCD decades, 1..8.
- REFRESH_DIV, 50000: clk cycles each digit is shown, ≥1.
- ACTIVE_LOW, 0: 1 inverts both seg and an at the output register.
- BLANK_LZ, 0: 1 blanks leading zero digits; digit 0 is never blanked.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  count enable, one step per cycle while high.
- up  in  1  direction: 1 increments, 0 decrements.
- load  in  1  synchronous load of load_val.
- load_val  in  4*DIGITS  BCD value; digit i in bits [4i+3:4i].
- bcd  out  4*DIGITS  current count, registered.
- carry  out  1  one-cycle pulse on wrap, either direction.
- seg  out  7  segments {g,f,e,d,c,b,a}, registered.
- an  out  DIGITS  one-hot digit select, registered.

## Operation
- Priority: reset > load > en. With load=1, en and up are ignored and carry=0.
- Load: any load_val nibble above 9 (A–F) loads as 0. All other nibbles load unchanged.
- Up count: 0 to 10^DIGITS−1. From all-9s the count goes to all-0s, and carry=1 in the same cycle bcd shows 0.
- Down count: from all-0s the count goes to all-9s, with carry=1 in the same cycle.
- Decade ripple is combinational within one cycle. Digit i steps when every lower digit is 9 (up) or 0 (down).
- en=0: bcd holds and carry=0.
- Mux:
  - refresh counter runs 0..REFRESH_DIV−1 and is free-running, independent of en.
  - At terminal count, digit index advances and wraps DIGITS−1 → 0.
- Decode table (active-high):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
- Blanking: when BLANK_LZ=1, digit k>0 is blanked if it and all higher digits are 0. A blanked digit drives seg=0000000 before polarity is applied. an still advances normally.
- Polarity: when ACTIVE_LOW=1, seg and an are bitwise inverted at the output register.
- Reset values:
  - bcd=0, carry=0, refresh counter=0, digit index=0.
  - an=one-hot bit 0, seg=0111111 (both before polarity).

## Timing
- bcd and carry update at the edge where en or load is sampled: 1-cycle latency from input to output.
- seg and an are registered from the current bcd and digit index. The display therefore lags bcd by one cycle.
- Digit index changes every REFRESH_DIV cycles, so a full display frame is DIGITS*REFRESH_DIV cycles.
- load or en in the same cycle as a refresh rollover are both honoured: they are independent paths.
- Reset mid-count or mid-frame: the cycle after reset, every register holds its reset value and the frame restarts at digit 0.

## Structure
- Package bcd7seg_pkg holds:
  - typedef seg_t (logic [6:0]);
  - constant array SEG_LUT[10];
  - function bcd_to_seg(nibble, blank), which returns 0 for blank or for a nibble above 9.
- Sub-module bcd_digit_cell: one decade with inputs step, up, load, load_nibble and outputs digit and wrap.
- The top level instantiates DIGITS cells in a generate loop, chaining wrap into the next cell's step.
- Refresh counter, digit index, blank logic and output registers live in the top level.

## Test plan
- DIGITS=2, reset, then en=1, up=1 for 99 cycles: bcd=8'h99, carry=0 throughout. On the next cycle bcd=8'h00 and carry=1 for exactly one cycle.
- DIGITS=2 at 0, en=1, up=0 for one cycle: bcd=8'h99, carry=1. A further cycle gives bcd=8'h98, carry=0.
- load=1, en=1, load_val=8'h57: bcd=8'h57, carry=0. Then load_val=8'h5A: bcd=8'h50.
- DIGITS=4, REFRESH_DIV=4, bcd loaded 16'h1207, ACTIVE_LOW=0:
  - an steps 0001 → 0010 → 0100 → 1000 → 0001, each held 4 cycles;
  - seg is 0000111 while an=0001 and 0000110 while an=1000.
- BLANK_LZ=1, DIGITS=4, value 16'h0042: seg=0000000 while an=0100 or 1000. Value 0: digit 0 shows 0111111.
- Reset for one cycle while en=1 with count at 16'h0345 and an=0100:
  - next cycle bcd=0, carry=0, an=0001, seg=0111111;
  - refresh restarts, and the next an change comes exactly REFRESH_DIV cycles later.

Source files
------------

// File: rtl/bcd7seg_pkg.sv
// bcd7seg_pkg: segment type, BCD decode table and decode helper shared by the counter display.
package bcd7seg_pkg;
    typedef logic [6:0] seg_t;
    localparam seg_t SEG_LUT [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };
    function automatic seg_t bcd_to_seg(input logic [3:0] nibble, input logic blank);
        return (blank || nibble > 4'd9) ? '0 : SEG_LUT[nibble];
    endfunction
endpackage

// File: rtl/bcd_digit_cell.sv
// bcd_digit_cell: one BCD decade with load, up/down step and combinational wrap to the next decade.
module bcd_digit_cell (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_nibble,
    output logic [3:0] digit,
    output logic       wrap
);
    logic [3:0] digit_q, digit_d;
    always_comb begin
        digit_d = load ? (load_nibble > 4'd9 ? 4'd0 : load_nibble)
                : step ? (up ? (digit_q == 4'd9 ? 4'd0 : digit_q + 4'd1)
                             : (digit_q == 4'd0 ? 4'd9 : digit_q - 4'd1))
                : digit_q;
    end
    always_ff @(posedge clk) begin
        if (reset) digit_q <= 4'd0;
        else       digit_q <= digit_d;
    end
    assign digit = digit_q;
    assign wrap  = step && (up ? digit_q == 4'd9 : digit_q == 4'd0);
endmodule

// File: rtl/bcd_counter_mux7seg.sv
// bcd_counter_mux7seg: multi-decade BCD up/down counter driving a time-multiplexed seven-segment display.
module bcd_counter_mux7seg
    import bcd7seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b0,
    parameter bit BLANK_LZ    = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] bcd,
    output logic                carry,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an
);
    localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    logic [DIGITS:0]      step;
    logic                 carry_q;
    logic [RW-1:0]        ref_q, ref_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DIGITS-1:0]    zero_up, an_d, an_q;
    logic                 ref_last, blank;
    seg_t                 seg_d, seg_q;
    assign step[0] = en && !load;
    for (genvar i = 0; i < DIGITS; i++) begin : g_cell
        bcd_digit_cell u_cell (
            .clk        (clk),
            .reset      (reset),
            .step       (step[i]),
            .up         (up),
            .load       (load),
            .load_nibble(load_val[4*i +: 4]),
            .digit      (bcd[4*i +: 4]),
            .wrap       (step[i+1])
        );
    end
    // display is driven from the next digit index so an changes exactly every REFRESH_DIV cycles
    always_comb begin
        ref_last = ref_q == RW'(REFRESH_DIV - 1);
        ref_d    = ref_last ? '0 : ref_q + RW'(1);
        idx_d    = !ref_last ? idx_q : (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + IW'(1));
        zero_up  = '0;
        zero_up[DIGITS-1] = bcd[4*DIGITS-1 -: 4] == 4'd0;
        for (int k = DIGITS - 2; k >= 0; k--) zero_up[k] = zero_up[k+1] && bcd[4*k +: 4] == 4'd0;
        blank    = BLANK_LZ && idx_d != '0 && zero_up[idx_d];
        seg_d    = bcd_to_seg(bcd[4*idx_d +: 4], blank);
        an_d     = DIGITS'(1) << idx_d;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q <= 1'b0;
            ref_q   <= '0;
            idx_q   <= '0;
            seg_q   <= ACTIVE_LOW ? ~SEG_LUT[0] : SEG_LUT[0];
            an_q    <= ACTIVE_LOW ? ~DIGITS'(1) : DIGITS'(1);
        end else begin
            carry_q <= step[DIGITS];
            ref_q   <= ref_d;
            idx_q   <= idx_d;
            seg_q   <= ACTIVE_LOW ? ~seg_d : seg_d;
            an_q    <= ACTIVE_LOW ? ~an_d : an_d;
        end
    end
    assign carry = carry_q;
    assign seg   = seg_q;
    assign an    = an_q;
endmodule
